// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge types: transfer/response encodings and the error FSM states.
package ahb_apb_pkg;

  localparam int HTRANS_W = 2;
  localparam int HRESP_W  = 2;

  typedef enum logic [HTRANS_W-1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [HRESP_W-1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_st_t;

endpackage

// File: rtl/ahb_addr_decoder.sv
// Maps an AHB address onto NUM_SLV equal-size APB regions starting at BASE_ADDR.
module ahb_addr_decoder #(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                REG_LOG2  = 26
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               in_map,
  output logic [NUM_SLV-1:0] sel
);

  // One extra bit keeps the offset from wrapping near the top of the address space.
  logic [ADDR_W:0] off;
  logic [ADDR_W:0] idx;

  assign off    = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign idx    = off >> REG_LOG2;
  assign in_map = (addr >= BASE_ADDR) && (idx < (ADDR_W+1)'(NUM_SLV));

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (in_map && (idx == (ADDR_W+1)'(i))) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_slave_if_mp.sv
// AHB slave front end for the AHB2APB bridge: region decode, stall-aware pipeline,
// and an optional two-cycle ERROR response for unmapped transfers (AHB_ERR_RESP_EN).
module ahb_slave_if_mp
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                REG_LOG2  = 26
) (
  input  logic                Hclk,
  input  logic                Hresetn,
  input  logic                Hwrite,
  input  logic                Hreadyin,
  input  logic [HTRANS_W-1:0] Htrans,
  input  logic [ADDR_W-1:0]   Haddr,
  input  logic [DATA_W-1:0]   Hwdata,
  input  logic [DATA_W-1:0]   Prdata,
  output logic                valid,
  output logic [ADDR_W-1:0]   Haddr1,
  output logic [ADDR_W-1:0]   Haddr2,
  output logic [DATA_W-1:0]   Hwdata1,
  output logic [DATA_W-1:0]   Hwdata2,
  output logic                Hwritereg,
  output logic [NUM_SLV-1:0]  tempselx,
  output logic [DATA_W-1:0]   Hrdata,
  output logic [HRESP_W-1:0]  Hresp,
  output logic                Hreadyout
);

  logic               act;
  logic               in_map;
  logic [NUM_SLV-1:0] sel_raw;
  logic               no_valid;

  ahb_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(BASE_ADDR),
    .REG_LOG2 (REG_LOG2)
  ) u_dec (
    .addr  (Haddr),
    .in_map(in_map),
    .sel   (sel_raw)
  );

  assign act      = Hreadyin && Htrans[1];
  assign valid    = Hresetn && act && in_map && !no_valid;
  assign tempselx = Hresetn ? sel_raw : '0;
  assign Hrdata   = Prdata;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwdata2   <= '0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

`ifdef AHB_ERR_RESP_EN
  err_st_t err_st;
  hresp_t  hresp_q;
  logic    hready_q;
  logic    err_hit;

  assign err_hit   = act && !in_map;
  // The first error cycle is a forced wait state, so Htrans is not a real address phase.
  assign no_valid  = (err_st == ST_ERR1);
  assign Hresp     = hresp_q;
  assign Hreadyout = hready_q;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      err_st   <= ST_IDLE;
      hresp_q  <= RESP_OKAY;
      hready_q <= 1'b1;
    end else begin
      case (err_st)
        ST_IDLE: begin
          if (err_hit) begin
            err_st   <= ST_ERR1;
            hresp_q  <= RESP_ERROR;
            hready_q <= 1'b0;
          end
        end
        ST_ERR1: begin
          err_st   <= ST_ERR2;
          hresp_q  <= RESP_ERROR;
          hready_q <= 1'b1;
        end
        ST_ERR2: begin
          if (err_hit) begin
            err_st   <= ST_ERR1;
            hresp_q  <= RESP_ERROR;
            hready_q <= 1'b0;
          end else begin
            err_st   <= ST_IDLE;
            hresp_q  <= RESP_OKAY;
            hready_q <= 1'b1;
          end
        end
        default: begin
          err_st   <= ST_IDLE;
          hresp_q  <= RESP_OKAY;
          hready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  assign no_valid  = 1'b0;
  assign Hresp     = RESP_OKAY;
  assign Hreadyout = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_if_mp.sv
// Randomised self-checking bench for ahb_slave_if_mp: default instance plus a NUM_SLV=5, REG_LOG2=24 instance.
module tb_ahb_slave_if_mp;

`ifdef AHB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        Hclk, Hresetn, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata;

  logic        valid_a, hwritereg_a, hreadyout_a;
  logic [31:0] haddr1_a, haddr2_a, hwdata1_a, hwdata2_a, hrdata_a;
  logic [2:0]  tempselx_a;
  logic [1:0]  hresp_a;

  logic        valid_b, hwritereg_b, hreadyout_b;
  logic [31:0] haddr1_b, haddr2_b, hwdata1_b, hwdata2_b, hrdata_b;
  logic [4:0]  tempselx_b;
  logic [1:0]  hresp_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_a1, m_a2, m_d1, m_d2;
  logic        m_w;
  int          m_err [2];
  int          nslv [2] = '{3, 5};
  int          lg2  [2] = '{26, 24};
  logic [31:0] addr_pool [12];

  ahb_slave_if_mp u_dut_a (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .valid(valid_a), .Haddr1(haddr1_a), .Haddr2(haddr2_a), .Hwdata1(hwdata1_a),
    .Hwdata2(hwdata2_a), .Hwritereg(hwritereg_a), .tempselx(tempselx_a),
    .Hrdata(hrdata_a), .Hresp(hresp_a), .Hreadyout(hreadyout_a)
  );

  ahb_slave_if_mp #(.NUM_SLV(5), .REG_LOG2(24)) u_dut_b (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .valid(valid_b), .Haddr1(haddr1_b), .Haddr2(haddr2_b), .Hwdata1(hwdata1_b),
    .Hwdata2(hwdata2_b), .Hwritereg(hwritereg_b), .tempselx(tempselx_b),
    .Hrdata(hrdata_b), .Hresp(hresp_b), .Hreadyout(hreadyout_b)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Region select from plain arithmetic: which region-sized slot above 0x8000_0000 holds the address.
  function automatic logic [7:0] ref_sel(input logic [31:0] a, input int n, input int l);
    longint unsigned la, slot;
    la = {32'd0, a};
    if (la < 64'h8000_0000) return 8'd0;
    slot = (la - 64'h8000_0000) >> l;
    if (slot < longint'(n)) return 8'd1 << slot;
    return 8'd0;
  endfunction

  function automatic logic exp_valid(input int k);
    logic act;
    act = Hreadyin && Htrans[1];
    return Hresetn && act && (ref_sel(Haddr, nslv[k], lg2[k]) != 0) && !(ERR_EN && m_err[k] == 1);
  endfunction

  task automatic compare_comb();
    checkOutput("a.valid", valid_a, exp_valid(0));
    checkOutput("b.valid", valid_b, exp_valid(1));
    checkOutput("a.tempselx", tempselx_a, Hresetn ? ref_sel(Haddr, 3, 26) : 8'd0);
    checkOutput("b.tempselx", tempselx_b, Hresetn ? ref_sel(Haddr, 5, 24) : 8'd0);
    checkOutput("a.hrdata", hrdata_a, Prdata);
    checkOutput("b.hrdata", hrdata_b, Prdata);
  endtask

  task automatic model_edge();
    logic act;
    act = Hreadyin && Htrans[1];
    for (int k = 0; k < 2; k++) begin
      if (!ERR_EN) m_err[k] = 0;
      else if (m_err[k] == 1) m_err[k] = 2;
      else if (act && ref_sel(Haddr, nslv[k], lg2[k]) == 0) m_err[k] = 1;
      else m_err[k] = 0;
    end
    if (Hreadyin) begin
      m_a2 = m_a1; m_a1 = Haddr;
      m_d2 = m_d1; m_d1 = Hwdata;
      m_w  = Hwrite;
    end
  endtask

  task automatic compare_regs();
    checkOutput("a.haddr1", haddr1_a, m_a1);
    checkOutput("a.haddr2", haddr2_a, m_a2);
    checkOutput("a.hwdata1", hwdata1_a, m_d1);
    checkOutput("a.hwdata2", hwdata2_a, m_d2);
    checkOutput("a.hwritereg", hwritereg_a, m_w);
    checkOutput("b.haddr1", haddr1_b, m_a1);
    checkOutput("b.hwdata2", hwdata2_b, m_d2);
    checkOutput("a.hresp", hresp_a, (m_err[0] != 0) ? 2'b01 : 2'b00);
    checkOutput("a.hreadyout", hreadyout_a, m_err[0] != 1);
    checkOutput("b.hresp", hresp_b, (m_err[1] != 0) ? 2'b01 : 2'b00);
    checkOutput("b.hreadyout", hreadyout_b, m_err[1] != 1);
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    Hwrite = w; Hreadyin = r; Htrans = t; Haddr = a; Hwdata = d; Prdata = p;
  endtask

  task automatic stepCycle();
    compare_comb();
    @(posedge Hclk);
    model_edge();
    #1;
    compare_regs();
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [1:0] t,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    drive(w, r, t, a, d, p);
    #3;
    stepCycle();
  endtask

  task automatic model_reset();
    m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w = 1'b0;
    m_err[0] = 0; m_err[1] = 0;
  endtask

  initial begin
    addr_pool = '{32'h8000_0000, 32'h8000_0004, 32'h83FF_FFFC, 32'h8400_0010,
                  32'h8500_0000, 32'h84FF_FFFC, 32'h8800_0000, 32'h8BFF_FFFC,
                  32'h8C00_0000, 32'h7FFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC};
    model_reset();
    Hresetn = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    #3;
    compare_comb();
    compare_regs();
    #9 Hresetn = 1'b1;
    @(posedge Hclk);
    model_edge();
    #1;

    $display("[TB] basic write to region 1");
    drive(1'b1, 1'b1, 2'b10, 32'h8400_0010, 32'hDEAD_BEEF, 32'h1234_5678);
    #3;
    checkOutput("a.sel_8400", tempselx_a, 3'b010);
    checkOutput("a.valid_8400", valid_a, 1'b1);
    stepCycle();
    checkOutput("a.haddr1_8400", haddr1_a, 32'h8400_0010);
    checkOutput("a.hwritereg_8400", hwritereg_a, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
    checkOutput("a.hwdata2_beef", hwdata2_a, 32'hDEAD_BEEF);

    $display("[TB] stall");
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'h1111_1111, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b10, 32'h8800_0000, 32'h2222_2222, 32'h0);
      checkOutput("a.stall_haddr1", haddr1_a, 32'h8000_0000);
    end

    $display("[TB] unmapped");
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h8C00_0000, 32'h0, 32'h0);
    checkOutput("a.unm_resp1", hresp_a, ERR_EN ? 2'b01 : 2'b00);
    checkOutput("a.unm_rdy1", hreadyout_a, ERR_EN ? 1'b0 : 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h8C00_0000, 32'h0, 32'h0);
    checkOutput("a.unm_resp2", hresp_a, ERR_EN ? 2'b01 : 2'b00);
    checkOutput("a.unm_rdy2", hreadyout_a, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h8C00_0000, 32'h0, 32'h0);
    checkOutput("a.unm_resp3", hresp_a, 2'b00);

    $display("[TB] back-to-back errors");
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0);
    checkOutput("a.b2b_rdy0", hreadyout_a, ERR_EN ? 1'b0 : 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
    checkOutput("a.b2b_rdy1", hreadyout_a, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0);
    checkOutput("a.b2b_rdy2", hreadyout_a, ERR_EN ? 1'b0 : 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
    checkOutput("a.b2b_rdy3", hreadyout_a, 1'b1);

    $display("[TB] async reset in first error cycle");
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h8C00_0000, 32'h5555_AAAA, 32'h0);
    drive(1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'h7777_7777, 32'h0);
    #2 Hresetn = 1'b0;
    #1;
    model_reset();
    checkOutput("a.rst_resp", hresp_a, 2'b00);
    checkOutput("a.rst_rdy", hreadyout_a, 1'b1);
    compare_comb();
    compare_regs();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    #2 Hresetn = 1'b1;
    @(posedge Hclk);
    model_edge();
    #1;
    compare_regs();

    $display("[TB] five-region instance");
    drive(1'b0, 1'b1, 2'b10, 32'h8400_0000, 32'h0, 32'hCAFE_F00D);
    #3;
    checkOutput("b.sel_8400", tempselx_b, 5'b10000);
    stepCycle();
    drive(1'b0, 1'b1, 2'b10, 32'h8500_0000, 32'h0, 32'h0);
    #3;
    checkOutput("b.sel_8500", tempselx_b, 5'b00000);
    checkOutput("a.sel_8500", tempselx_a, 3'b010);
    stepCycle();
    checkOutput("b.resp_8500", hresp_b, ERR_EN ? 2'b01 : 2'b00);
    checkOutput("a.resp_8500", hresp_a, 2'b00);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 5) == 0) ? $urandom() : addr_pool[$urandom_range(0, 11)];
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), a, $urandom(), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if_mp.md
Name: ahb_slave_if_mp

Overview:
Parametrised AHB slave front end for the AHB2APB bridge, decoding NUM_SLV equal-size APB regions from a programmable base address. Provides a stall-aware two-stage address/data/control pipeline for the bridge FSM. Adds a two-cycle AHB ERROR response for transfers to unmapped addresses. Sits between the AHB interconnect and the bridge APB controller FSM.

Parameters:
- ADDR_W, 32: width of Haddr and the address pipeline registers.
- DATA_W, 32: width of Hwdata, Prdata, Hrdata and the data pipeline registers.
- NUM_SLV, 3: number of APB slave regions; sets the width of tempselx; range 1..8.
- BASE_ADDR, 32'h8000_0000: start address of region 0.
- REG_LOG2, 26: log2 of the region size in bytes (26 gives 0x0400_0000).

Ports:
- Hclk  in  1  bus clock; all flops on the rising edge.
- Hresetn  in  1  reset; asynchronous, active-low.
- Hwrite  in  1  AHB write indication (address phase).
- Hreadyin  in  1  AHB HREADY from the interconnect.
- Htrans  in  2  AHB transfer type.
- Haddr  in  ADDR_W  AHB address.
- Hwdata  in  DATA_W  AHB write data (data phase).
- Prdata  in  DATA_W  APB read data from the selected slave.
- valid  out  1  mapped, active transfer in the current address phase.
- Haddr1, Haddr2  out  ADDR_W  address pipeline, stages 1 and 2.
- Hwdata1, Hwdata2  out  DATA_W  write-data pipeline, stages 1 and 2.
- Hwritereg  out  1  registered Hwrite.
- tempselx  out  NUM_SLV  one-hot region select, combinational from Haddr.
- Hrdata  out  DATA_W  read data to AHB.
- Hresp  out  2  00 OKAY, 01 ERROR.
- Hreadyout  out  1  slave ready; low only in the first error cycle.

Behaviour:
- Reset (async, Hresetn=0):
  - All pipeline registers, Hwritereg and the error FSM clear immediately: FSM to IDLE, Hresp=00, Hreadyout=1.
  - valid=0 and tempselx=0 while Hresetn=0 (combinationally gated).
- Active transfer: act = Hreadyin && Htrans[1] (NONSEQ=10 or SEQ=11). IDLE (00) and BUSY (01) get OKAY with zero wait states.
- Decode:
  - off = Haddr - BASE_ADDR; idx = off >> REG_LOG2.
  - in_map = (Haddr >= BASE_ADDR) && (idx < NUM_SLV), computed at full ADDR_W+1 width so no wrap at the top of the address space.
  - tempselx[idx]=1 when in_map, otherwise all zero.
  - valid = act && in_map.
- Pipeline:
  - Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwritereg<=Hwrite.
  - Each update happens only when Hreadyin=1; all registers hold while Hreadyin=0.
  - Latency: stage 1 appears 1 cycle after the accepted address phase, stage 2 after 2 accepted cycles.
- Error FSM, states IDLE, ERR1, ERR2:
  - IDLE: Hresp=00, Hreadyout=1. Goes to ERR1 if act && !in_map.
  - ERR1: Hresp=01, Hreadyout=0. Always goes to ERR2. Inputs are ignored; no valid is generated from Htrans.
  - ERR2: Hresp=01, Hreadyout=1. Returns to IDLE, or re-enters ERR1 if act && !in_map is sampled again.
  - A mapped act in ERR2 is a normal new address phase: valid=1 and FSM returns to IDLE.
- Hrdata = Prdata (combinational passthrough).
- Reset asserted in ERR1 or ERR2: FSM goes to IDLE immediately; Hresp=00 and Hreadyout=1 without waiting for a clock edge.

Optional Feature:
AHB_ERR_RESP_EN
- Defined: error FSM as above.
- Undefined: FSM is not compiled. Hresp is tied to 00 and Hreadyout to 1; unmapped transfers complete OKAY with zero wait states (legacy bridge behaviour). valid is still 0 for unmapped addresses.

Decomposition:
- Package ahb_apb_pkg holds:
  - htrans_t enum: IDLE, BUSY, NONSEQ, SEQ.
  - hresp_t enum: OKAY, ERROR, RETRY, SPLIT.
  - err_st_t enum: IDLE, ERR1, ERR2.
  - Localparams HTRANS_W=2 and HRESP_W=2.
- One sub-module, ahb_addr_decoder, is natural. It is parametrised by ADDR_W, NUM_SLV, BASE_ADDR and REG_LOG2, and outputs in_map and tempselx.

Test Plan:
- Defaults: NONSEQ write to 0x8400_0010 with Hwdata=0xDEAD_BEEF -> valid=1 and tempselx=010 that cycle; Haddr1=0x8400_0010 next cycle; Hwdata2=0xDEAD_BEEF 2 cycles later; Hwritereg=1.
- Stall: Hreadyin=0 for 3 cycles after the address phase at 0x8000_0000 -> Haddr1/Haddr2 hold their values; valid=0 throughout.
- Unmapped: NONSEQ to 0x8C00_0000 with macro defined -> cycle+1 Hresp=01 and Hreadyout=0; cycle+2 Hresp=01 and Hreadyout=1; cycle+3 Hresp=00. With macro undefined -> Hresp=00 and Hreadyout=1 every cycle.
- Back-to-back errors: unmapped NONSEQ to 0x0000_0000, then unmapped act sampled in ERR2 -> ERR2 goes to ERR1; Hreadyout pattern 0,1,0,1.
- Async reset: assert Hresetn=0 mid-ERR1 -> Hresp=00 and Hreadyout=1 before the next Hclk edge; all pipeline outputs read 0.
- Parameters NUM_SLV=5, REG_LOG2=24: Haddr=0x8400_0000 -> tempselx=10000; Haddr=0x8500_0000 -> tempselx=0 and error response.
